rf68000_ram_scheduler: RTL and testbench

RF68000_RAM_SCHEDULER -- requirements
Module: rf68000_ram_scheduler

---
 rtl/rf68000_sched_pkg.sv | 16 +
 rtl/rf68000_rr_pick.sv | 30 +++
 rtl/rf68000_ram_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_rf68000_ram_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf68000_sched_pkg.sv
// Shared types and constants for the RAM scheduler.
// Holds the FSM state type, the lock cap and the requester ceiling.
package rf68000_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK
  } state_t;

  localparam int unsigned LOCK_CAP = 16;
  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned CAP_W    = $clog2(LOCK_CAP + 1);

endpackage

// File: rtl/rf68000_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i after last_i.
// Ports: req_i request vector, last_i last winner, valid_o/idx_o result.
module rf68000_rr_pick
  import rf68000_sched_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic            valid_o,
  output logic [IW-1:0]   idx_o
);

  logic [IW-1:0] c;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    c       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c = IW'((int'(last_i) + k) % NREQ);
      if (!valid_o && req_i[c]) begin
        valid_o = 1'b1;
        idx_o   = c;
      end
    end
  end

endmodule

// File: rtl/rf68000_ram_scheduler.sv
// Arbitrates NREQ bus masters onto one latency-RAM_LAT RAM port.
// Ports: req_* per-master bus, ram_* RAM side, gnt_o debug grant.
module rf68000_ram_scheduler
  import rf68000_sched_pkg::*;
#(
  parameter int          NREQ     = 3,
  parameter int          RAM_LAT  = 2,
  parameter logic [31:0] RAM_BASE = 32'h0000_0000,
  parameter logic [31:0] RAM_MASK = 32'hFFFC_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_cyc,
  input  logic [NREQ-1:0]       req_stb,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ-1:0][3:0]  req_sel,
  input  logic [NREQ-1:0][31:0] req_adr,
  input  logic [NREQ-1:0][31:0] req_dato,
  output logic [NREQ-1:0][31:0] req_dati,
  output logic [NREQ-1:0]       req_ack,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_adr,
  output logic [31:0]           ram_dati,
  input  logic [31:0]           ram_dato,
  output logic [2:0]            gnt_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = $clog2(MAX_NREQ);
  localparam logic [2:0] LAT_INIT =
    (RAM_LAT > 1) ? 3'(RAM_LAT - 2) : 3'd0;
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam logic [CAP_W-1:0] CAP = CAP_W'(LOCK_CAP);

  state_t state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] last_gnt_q, last_gnt_d;
  logic lock_q, lock_d;
  logic [CAP_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [2:0] lat_cnt_q, lat_cnt_d;
  logic abort_q, abort_d;
  logic we_q, we_d;
  logic ack_q, ack_d;
  logic [31:0] dati_q, dati_d;
  logic ram_en_q, ram_en_d;
  logic [3:0] ram_we_q, ram_we_d;
  logic [31:0] ram_adr_q, ram_adr_d;
  logic [31:0] ram_dati_q, ram_dati_d;

  logic [NREQ-1:0] pend;
  logic [IW-1:0] pick_last;
  logic [IW-1:0] pick_idx;
  logic pick_valid;
  logic locked;
  logic go;
  logic hit;
  logic ab;
  logic done;
  logic [IW-1:0] sel_idx;

  always_comb begin
    req_ack = '0;
    req_dati = '0;
    req_ack[gnt_q] = ack_q;
    req_dati[gnt_q] = dati_q;
  end

  assign pend = req_cyc & req_stb & ~req_ack;

  // A lock that is lapsing this cycle hands priority past its owner.
  assign pick_last = lock_q ? gnt_q : last_gnt_q;

  rf68000_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i   (pend),
    .last_i  (pick_last),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign ram_en   = ram_en_q;
  assign ram_we   = ram_we_q;
  assign ram_adr  = ram_adr_q;
  assign ram_dati = ram_dati_q;
  assign gnt_o    = GW'(gnt_q);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    lock_d     = lock_q;
    xfer_cnt_d = xfer_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    abort_d    = abort_q;
    we_d       = we_q;
    ack_d      = ack_q;
    dati_d     = dati_q;
    ram_en_d   = ram_en_q;
    ram_we_d   = ram_we_q;
    ram_adr_d  = ram_adr_q;
    ram_dati_d = ram_dati_q;
    done       = 1'b0;

    locked  = lock_q && req_cyc[gnt_q]
              && (xfer_cnt_q < CAP);
    sel_idx = locked ? gnt_q : pick_idx;
    go      = locked ? pend[gnt_q] : pick_valid;
    hit     = (req_adr[sel_idx] & RAM_MASK)
              == RAM_BASE;
    ab      = abort_q | ~req_cyc[gnt_q];

    if (lock_q && !req_cyc[gnt_q]) begin
      lock_d     = 1'b0;
      last_gnt_d = gnt_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        // Cap reached: drop the lock for this round.
        if (!locked && lock_q) begin
          lock_d     = 1'b0;
          last_gnt_d = gnt_q;
        end
        if (go) begin
          gnt_d   = sel_idx;
          we_d    = req_we[sel_idx];
          abort_d = 1'b0;
          if (locked) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
          end else begin
            lock_d     = 1'b1;
            xfer_cnt_d = CAP_W'(1);
          end
          if (hit) begin
            state_d    = ST_ISSUE;
            ram_en_d   = 1'b1;
            ram_we_d   = {4{req_we[sel_idx]}}
                         & req_sel[sel_idx];
            ram_adr_d  = req_adr[sel_idx];
            ram_dati_d = req_dato[sel_idx];
          end else begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            dati_d  = '0;
          end
        end
      end
      ST_ISSUE: begin
        ram_we_d = '0;
        abort_d  = ab;
        if (RAM_LAT == 1) begin
          done = 1'b1;
        end else begin
          state_d   = ST_WAIT;
          lat_cnt_d = LAT_INIT;
        end
      end
      ST_WAIT: begin
        abort_d = ab;
        if (lat_cnt_q == 3'd0) begin
          done = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        ram_en_d = 1'b0;
        if (!req_stb[gnt_q]) begin
          ack_d   = 1'b0;
          dati_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // RAM sequence finished: ack unless the master walked away.
    if (done) begin
      ram_en_d = 1'b0;
      abort_d  = 1'b0;
      if (ab) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_ACK;
        ack_d   = 1'b1;
        dati_d  = we_q ? 32'h0 : ram_dato;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      last_gnt_q <= LAST_RST;
      lock_q     <= 1'b0;
      xfer_cnt_q <= '0;
      lat_cnt_q  <= '0;
      abort_q    <= 1'b0;
      we_q       <= 1'b0;
      ack_q      <= 1'b0;
      dati_q     <= '0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= '0;
      ram_adr_q  <= '0;
      ram_dati_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      lock_q     <= lock_d;
      xfer_cnt_q <= xfer_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      abort_q    <= abort_d;
      we_q       <= we_d;
      ack_q      <= ack_d;
      dati_q     <= dati_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_adr_q  <= ram_adr_d;
      ram_dati_q <= ram_dati_d;
    end
  end

endmodule

// File: tb/tb_rf68000_ram_scheduler.sv
// Self-checking bench for rf68000_ram_scheduler.
// Masters, a sync RAM model and a per-port scoreboard.
module tb_rf68000_ram_scheduler;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       req_cyc;
  logic [N-1:0]       req_stb;
  logic [N-1:0]       req_we;
  logic [N-1:0][3:0]  req_sel;
  logic [N-1:0][31:0] req_adr;
  logic [N-1:0][31:0] req_dato;
  logic [N-1:0][31:0] req_dati;
  logic [N-1:0]       req_ack;
  logic               ram_en;
  logic [3:0]         ram_we;
  logic [31:0]        ram_adr;
  logic [31:0]        ram_dati;
  logic [31:0]        ram_dato;
  logic [2:0]         gnt_o;

  rf68000_ram_scheduler #(
    .NREQ    (N),
    .RAM_LAT (2)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_cyc  (req_cyc),
    .req_stb  (req_stb),
    .req_we   (req_we),
    .req_sel  (req_sel),
    .req_adr  (req_adr),
    .req_dato (req_dato),
    .req_dati (req_dati),
    .req_ack  (req_ack),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_adr  (ram_adr),
    .ram_dati (ram_dati),
    .ram_dato (ram_dato),
    .gnt_o    (gnt_o)
  );

  function automatic logic [31:0] init_val(
    input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  bit [31:0] mem [1024];
  bit        mem_ok [1024];
  logic [31:0] rd_q;

  function automatic logic [31:0] ram_rd(
    input logic [31:0] a);
    if (mem_ok[a[11:2]]) return mem[a[11:2]];
    return init_val({a[31:2], 2'b00});
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      rd_q <= ram_rd(ram_adr);
      if (ram_we != 4'h0) begin
        mem[ram_adr[11:2]] <=
          merge(ram_rd(ram_adr), ram_dati, ram_we);
        mem_ok[ram_adr[11:2]] <= 1'b1;
      end
    end
  end
  assign ram_dato = rd_q;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;
  int rem [N];
  logic [31:0] b_adr [N];
  logic [31:0] b_dat [N];
  logic        b_we [N];
  logic [3:0]  b_sel [N];
  logic [31:0] expq [N][$];
  int served [$];
  int raise_cyc [N];
  int ack_cyc [N];
  int ack_total = 0;
  logic [N-1:0] ack_prev = '0;
  logic [N-1:0] ack_seen = '0;
  logic en_prev = 1'b0;
  int en_cnt = 0;
  int en_rise = 0;
  int we_cnt = 0;
  logic [3:0] we_val = '0;
  bit [31:0] sh [1024];
  bit        sh_ok [1024];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expect_for(
    input int p);
    logic [31:0] a, o;
    a = b_adr[p];
    if ((a & 32'hFFFC_0000) != 32'h0) return 32'h0;
    o = sh_ok[a[11:2]] ? sh[a[11:2]]
        : init_val({a[31:2], 2'b00});
    if (b_we[p]) begin
      sh[a[11:2]] = merge(o, b_dat[p], b_sel[p]);
      sh_ok[a[11:2]] = 1'b1;
      return 32'h0;
    end
    return o;
  endfunction

  task automatic master();
    for (int p = 0; p < N; p++) begin
      if (req_stb[p] && ack_seen[p]) begin
        req_stb[p] = 1'b0;
        rem[p]--;
        if (rem[p] == 0) req_cyc[p] = 1'b0;
      end else if (!req_stb[p] && rem[p] > 0) begin
        req_cyc[p]  = 1'b1;
        req_stb[p]  = 1'b1;
        req_we[p]   = b_we[p];
        req_sel[p]  = b_sel[p];
        req_adr[p]  = b_adr[p];
        req_dato[p] = b_dat[p];
        expq[p].push_back(expect_for(p));
        raise_cyc[p] = cyc_no;
      end
    end
  endtask

  task automatic mon();
    logic [31:0] e;
    chk("ack_1hot",
        32'($countones(req_ack) > 1), 32'h0);
    for (int p = 0; p < N; p++) begin
      if (int'(gnt_o) != p) begin
        chk("other_ack", 32'(req_ack[p]), 32'h0);
        chk("other_dati", req_dati[p], 32'h0);
      end
      if (req_ack[p] && !ack_prev[p]) begin
        ack_total++;
        ack_cyc[p] = cyc_no;
        served.push_back(p);
        if (expq[p].size() == 0) begin
          chk($sformatf("unexp_ack_p%0d", p),
              32'h1, 32'h0);
        end else begin
          e = expq[p].pop_front();
          chk($sformatf("data_p%0d", p),
              req_dati[p], e);
        end
      end
    end
    if (ram_en && !en_prev) begin
      en_cnt++;
      en_rise = cyc_no;
    end
    if (ram_we != 4'h0) begin
      we_cnt++;
      we_val = ram_we;
    end
    ack_prev = req_ack;
    ack_seen = req_ack;
    en_prev  = ram_en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_no++;
    master();
    @(negedge clk);
    mon();
  endtask

  task automatic burst(input int p, input int n,
                       input logic we,
                       input logic [3:0] sel,
                       input logic [31:0] adr,
                       input logic [31:0] dat);
    rem[p]   = n;
    b_we[p]  = we;
    b_sel[p] = sel;
    b_adr[p] = adr;
    b_dat[p] = dat;
  endtask

  function automatic bit busy();
    for (int p = 0; p < N; p++)
      if (rem[p] > 0 || expq[p].size() > 0)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (busy() && k < budget) begin
      step();
      k++;
    end
    chk("drain_timeout", 32'(busy()), 32'h0);
    repeat (3) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 32'(ram_en), 32'h0);
    chk({tag, "_we"}, 32'(ram_we), 32'h0);
    chk({tag, "_adr"}, ram_adr, 32'h0);
    chk({tag, "_dati"}, ram_dati, 32'h0);
    chk({tag, "_ack"}, 32'(req_ack), 32'h0);
    chk({tag, "_gnt"}, 32'(gnt_o), 32'h0);
    for (int p = 0; p < N; p++)
      chk({tag, "_rdat"}, req_dati[p], 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    req_cyc  = '0;
    req_stb  = '0;
    req_we   = '0;
    req_sel  = '0;
    req_adr  = '0;
    req_dato = '0;
    for (int p = 0; p < N; p++) begin
      rem[p] = 0;
      raise_cyc[p] = 0;
      ack_cyc[p] = 0;
    end
    rst = 1'b1;
    repeat (3) step();
    chk_zero("rst");
    rst = 1'b0;
    step();

    // CPU read, latency at RAM_LAT=2
    en_cnt = 0;
    burst(0, 1, 1'b0, 4'hF, 32'h100, 32'h0);
    drain(50);
    chk("t1_en_lat", 32'(en_rise - raise_cyc[0]), 32'd1);
    chk("t1_ack_lat", 32'(ack_cyc[0] - raise_cyc[0]), 32'd3);

    // NIC partial write, then CPU readback
    we_cnt = 0;
    burst(1, 1, 1'b1, 4'b0011, 32'h200, 32'h1234_5678);
    drain(50);
    chk("t2_we_cycles", 32'(we_cnt), 32'd1);
    chk("t2_we_val", 32'(we_val), 32'h3);
    chk("t2_ack_lat", 32'(ack_cyc[1] - raise_cyc[1]), 32'd3);
    burst(0, 1, 1'b0, 4'hF, 32'h200, 32'h0);
    drain(50);

    // DMA window miss
    en_cnt = 0;
    burst(2, 1, 1'b0, 4'hF, 32'h0100_0000, 32'h0);
    drain(50);
    chk("t3_no_en", 32'(en_cnt), 32'd0);
    chk("t3_ack_lat", 32'(ack_cyc[2] - raise_cyc[2]), 32'd1);

    // simultaneous requests, last_gnt=2
    served.delete();
    burst(0, 1, 1'b0, 4'hF, 32'h300, 32'h0);
    burst(1, 1, 1'b0, 4'hF, 32'h304, 32'h0);
    burst(2, 1, 1'b0, 4'hF, 32'h308, 32'h0);
    drain(100);
    chk("t4_cnt", 32'(served.size()), 32'd3);
    for (int i = 0; i < 3 && i < served.size(); i++)
      chk($sformatf("t4_order%0d", i),
          32'(served[i]), 32'(i));

    // lock cap: CPU 20 strobes under one cyc, NIC waiting
    served.delete();
    burst(0, 20, 1'b0, 4'hF, 32'h400, 32'h0);
    burst(1, 1, 1'b0, 4'hF, 32'h404, 32'h0);
    drain(400);
    chk("t5_cnt", 32'(served.size()), 32'd21);
    if (served.size() == 21) begin
      chk("t5_pre", 32'(served[15]), 32'd0);
      chk("t5_nic", 32'(served[16]), 32'd1);
      chk("t5_post", 32'(served[17]), 32'd0);
    end

    // reset pulse while NIC is in WAIT
    burst(1, 1, 1'b0, 4'hF, 32'h500, 32'h0);
    repeat (3) step();
    chk("t6_in_wait", 32'(ram_en), 32'h1);
    base = ack_total;
    rst = 1'b1;
    req_cyc[1] = 1'b0;
    req_stb[1] = 1'b0;
    rem[1] = 0;
    expq[1].delete();
    #1;
    chk_zero("t6_rst");
    repeat (2) step();
    rst = 1'b0;
    repeat (8) step();
    chk("t6_no_ack", 32'(ack_total), 32'(base));

    // CPU abandons cyc in WAIT
    burst(0, 1, 1'b0, 4'hF, 32'h600, 32'h0);
    repeat (3) step();
    chk("t7_in_wait", 32'(ram_en), 32'h1);
    base = ack_total;
    req_cyc[0] = 1'b0;
    req_stb[0] = 1'b0;
    rem[0] = 0;
    expq[0].delete();
    repeat (6) step();
    chk("t7_no_ack", 32'(ack_total), 32'(base));
    chk("t7_idle_en", 32'(ram_en), 32'h0);
    burst(1, 1, 1'b0, 4'hF, 32'h604, 32'h0);
    drain(50);
    chk("t7_next_lat", 32'(ack_cyc[1] - raise_cyc[1]), 32'd3);
    chk("t7_next_cnt", 32'(ack_total), 32'(base + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
